// File: rtl/elevator_call_scheduler_if.sv
// Call/dispatch bus between the hall/car call logic, the scheduler and the elevator core.
// SCHED_CANCEL_EN adds the call-cancel signals.
interface elevator_call_scheduler_if;
    logic        call_valid;
    logic [3:0]  call_floor;
    logic [3:0]  cur_floor;
    logic        complete;
    logic [3:0]  req_floor;
    logic        go;
    logic        door_open_req;
    logic        served;
    logic [15:0] pending;
    logic        dir_up;
    logic        busy;
`ifdef SCHED_CANCEL_EN
    logic        cancel_valid;
    logic [3:0]  cancel_floor;

    modport master (output call_valid, call_floor, cur_floor, complete, cancel_valid, cancel_floor,
                    input  req_floor, go, door_open_req, served, pending, dir_up, busy);
    modport slave  (input  call_valid, call_floor, cur_floor, complete, cancel_valid, cancel_floor,
                    output req_floor, go, door_open_req, served, pending, dir_up, busy);
`else
    modport master (output call_valid, call_floor, cur_floor, complete,
                    input  req_floor, go, door_open_req, served, pending, dir_up, busy);
    modport slave  (input  call_valid, call_floor, cur_floor, complete,
                    output req_floor, go, door_open_req, served, pending, dir_up, busy);
`endif
endinterface

// File: rtl/elevator_call_scheduler.sv
// SCAN elevator call scheduler: latches calls, picks the next floor in the sweep direction,
// dispatches it and runs the door dwell. SCHED_CANCEL_EN enables call cancellation.
module elevator_call_scheduler #(
    parameter int DWELL_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    elevator_call_scheduler_if.slave    bus
);
    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_DISPATCH, S_TRAVEL, S_DWELL} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_pending, w_pending_nxt, w_set, w_clr, w_cancel;
    logic [3:0]  r_req_floor, r_target, w_target;
    logic        r_go, r_served, r_dir_up, w_dir_nxt, w_enter_dwell;
    logic [7:0]  r_cnt;
    logic        w_has_above, w_has_below;
    logic [3:0]  w_lo_above, w_hi_below;

    // Candidate floors strictly above/below the car; cur_floor itself is never a candidate.
    always_comb begin
        w_has_above = 1'b0;
        w_lo_above  = 4'd0;
        w_has_below = 1'b0;
        w_hi_below  = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_pending[i] && (4'(i) > bus.cur_floor)) begin
                w_has_above = 1'b1;
                w_lo_above  = 4'(i);
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (r_pending[i] && (4'(i) < bus.cur_floor)) begin
                w_has_below = 1'b1;
                w_hi_below  = 4'(i);
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_target      = r_target;
        w_dir_nxt     = r_dir_up;
        w_enter_dwell = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending[bus.cur_floor]) begin
                    w_next        = S_DWELL;
                    w_enter_dwell = 1'b1;
                end else if (|r_pending) begin
                    w_next = S_SELECT;
                end
            end
            S_SELECT: begin
                w_next = S_DISPATCH;
                if (r_dir_up) begin
                    if (w_has_above) w_target = w_lo_above;
                    else if (w_has_below) begin
                        w_target  = w_hi_below;
                        w_dir_nxt = 1'b0;
                    end else w_next = S_IDLE;
                end else begin
                    if (w_has_below) w_target = w_hi_below;
                    else if (w_has_above) begin
                        w_target  = w_lo_above;
                        w_dir_nxt = 1'b1;
                    end else w_next = S_IDLE;
                end
            end
            S_DISPATCH: w_next = S_TRAVEL;
            S_TRAVEL: begin
                if (bus.complete && (bus.cur_floor == r_req_floor)) begin
                    w_next        = S_DWELL;
                    w_enter_dwell = 1'b1;
                end
            end
            S_DWELL: if (r_cnt <= 8'd1) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Clear beats set for the floor being served, so same-floor calls at the door are absorbed.
    always_comb begin
        w_set = bus.call_valid ? (16'd1 << bus.call_floor) : 16'd0;
        w_clr = (w_enter_dwell || (r_state == S_DWELL)) ? (16'd1 << bus.cur_floor) : 16'd0;
`ifdef SCHED_CANCEL_EN
        w_cancel = bus.cancel_valid ? (16'd1 << bus.cancel_floor) : 16'd0;
        if (r_state == S_TRAVEL) w_cancel[r_req_floor] = 1'b0;
`else
        w_cancel = 16'd0;
`endif
        w_pending_nxt = ((r_pending & ~w_cancel) | w_set) & ~w_clr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pending   <= 16'd0;
            r_req_floor <= 4'd0;
            r_target    <= 4'd0;
            r_go        <= 1'b0;
            r_served    <= 1'b0;
            r_dir_up    <= 1'b1;
            r_cnt       <= 8'd0;
        end else begin
            r_state   <= w_next;
            r_pending <= w_pending_nxt;
            r_target  <= w_target;
            r_dir_up  <= w_dir_nxt;
            r_served  <= w_enter_dwell;
            r_go      <= (r_state == S_DISPATCH);
            if (r_state == S_DISPATCH) r_req_floor <= r_target;
            if (w_enter_dwell)         r_cnt <= 8'(DWELL_CYCLES);
            else if (r_cnt != 8'd0)    r_cnt <= r_cnt - 8'd1;
        end
    end

    assign bus.req_floor     = r_req_floor;
    assign bus.go            = r_go;
    assign bus.door_open_req = (r_cnt != 8'd0);
    assign bus.served        = r_served;
    assign bus.pending       = r_pending;
    assign bus.dir_up        = r_dir_up;
    assign bus.busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler (DWELL_CYCLES=4); cancel scenario under SCHED_CANCEL_EN.
module tb_elevator_call_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    elevator_call_scheduler_if bus();
    elevator_call_scheduler #(.DWELL_CYCLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        bus.call_valid = 1'b0; bus.call_floor = 4'd0; bus.complete = 1'b0;
`ifdef SCHED_CANCEL_EN
        bus.cancel_valid = 1'b0; bus.cancel_floor = 4'd0;
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic call(input logic [3:0] f);
        bus.call_valid = 1'b1; bus.call_floor = f;
        @(negedge clk);
        bus.call_valid = 1'b0;
    endtask

    task automatic wait_go(output int lat);
        lat = 0;
        while (bus.go !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic arrive(input logic [3:0] f, output logic sv);
        bus.cur_floor = f; bus.complete = 1'b1;
        @(negedge clk);
        sv = bus.served;
        bus.complete = 1'b0;
    endtask

    task automatic count_door(output int n);
        n = 0;
        while (bus.door_open_req === 1'b1 && n < 20) begin n++; @(negedge clk); end
    endtask

    task automatic test_reset();
        bus.cur_floor = 4'd0;
        do_reset();
        n_cmp++; if (bus.pending !== 16'd0 || bus.req_floor !== 4'd0) begin n_bad++;
            $display("FAIL reset_regs: pending=%h req=%0d, expected 0000/0", bus.pending, bus.req_floor); end
        n_cmp++; if ({bus.go, bus.door_open_req, bus.served, bus.dir_up, bus.busy} !== 5'b00010) begin n_bad++;
            $display("FAIL reset_flags: go,door,served,dir,busy=%b, expected 00010",
                     {bus.go, bus.door_open_req, bus.served, bus.dir_up, bus.busy}); end
    endtask

    task automatic test_basic();
        int n; logic sv;
        do_reset(); bus.cur_floor = 4'd2;
        call(4'd7);
        n = 0;
        while (bus.busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        wait_go(n);
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL basic_latency: got %0d expected 2", n); end
        n_cmp++; if (bus.req_floor !== 4'd7 || bus.dir_up !== 1'b1) begin n_bad++;
            $display("FAIL basic_dispatch: req=%0d dir=%b expected 7/1", bus.req_floor, bus.dir_up); end
        @(negedge clk);
        n_cmp++; if (bus.go !== 1'b0) begin n_bad++; $display("FAIL basic_go_once: go=%b expected 0", bus.go); end
        arrive(4'd7, sv);
        n_cmp++; if (sv !== 1'b1 || bus.pending !== 16'd0) begin n_bad++;
            $display("FAIL basic_serve: served=%b pending=%h expected 1/0000", sv, bus.pending); end
        count_door(n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL basic_dwell: door cycles %0d expected 4", n); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle: busy=%b expected 0", bus.busy); end
    endtask

    task automatic test_same_floor();
        int n; logic gos;
        do_reset(); bus.cur_floor = 4'd4;
        call(4'd4);
        gos = bus.go;
        @(negedge clk);
        gos = gos | bus.go;
        n_cmp++; if (bus.served !== 1'b1 || bus.pending !== 16'd0) begin n_bad++;
            $display("FAIL same_serve: served=%b pending=%h expected 1/0000", bus.served, bus.pending); end
        n = 0;
        while (bus.door_open_req === 1'b1 && n < 20) begin n++; gos = gos | bus.go; @(negedge clk); end
        n_cmp++; if (n !== 4 || gos !== 1'b0) begin n_bad++;
            $display("FAIL same_dwell: door=%0d go_seen=%b expected 4/0", n, gos); end
    endtask

    task automatic test_scan_order();
        int n; logic sv;
        logic [3:0] exp_f [3] = '{4'd6, 4'd8, 4'd3};
        logic       exp_d [3] = '{1'b1, 1'b1, 1'b0};
        do_reset(); bus.cur_floor = 4'd5;
        call(4'd5);
        call(4'd3); call(4'd8); call(4'd6);
        n_cmp++; if (bus.pending !== 16'h0148) begin n_bad++;
            $display("FAIL scan_pending: got %h expected 0148", bus.pending); end
        for (int k = 0; k < 3; k++) begin
            wait_go(n);
            n_cmp++; if (n >= 40 || bus.req_floor !== exp_f[k] || bus.dir_up !== exp_d[k]) begin n_bad++;
                $display("FAIL scan_step%0d: req=%0d dir=%b expected %0d/%b", k, bus.req_floor, bus.dir_up, exp_f[k], exp_d[k]); end
            arrive(exp_f[k], sv);
            n_cmp++; if (sv !== 1'b1) begin n_bad++; $display("FAIL scan_served%0d: got %b expected 1", k, sv); end
        end
        n_cmp++; if (bus.pending !== 16'd0) begin n_bad++; $display("FAIL scan_empty: got %h expected 0000", bus.pending); end
    endtask

    task automatic test_entry_cycle();
        int n;
        do_reset(); bus.cur_floor = 4'd6;
        call(4'd6); call(4'd10);
        n_cmp++; if (bus.pending !== 16'h0400 || bus.served !== 1'b1) begin n_bad++;
            $display("FAIL entry_merge: pending=%h served=%b expected 0400/1", bus.pending, bus.served); end
        n = 0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); if (bus.served === 1'b1) n++; end
        n_cmp++; if (n !== 0) begin n_bad++; $display("FAIL entry_served_once: extra pulses %0d expected 0", n); end
        do_reset(); bus.cur_floor = 4'd6;
        call(4'd6); call(4'd6);
        n_cmp++; if (bus.pending !== 16'd0 || bus.served !== 1'b1) begin n_bad++;
            $display("FAIL entry_absorb: pending=%h served=%b expected 0000/1", bus.pending, bus.served); end
        call(4'd6);
        n_cmp++; if (bus.pending !== 16'd0) begin n_bad++; $display("FAIL dwell_absorb: got %h expected 0000", bus.pending); end
    endtask

    task automatic test_reset_travel();
        int n;
        do_reset(); bus.cur_floor = 4'd10;
        call(4'd9); call(4'd8);
        wait_go(n);
        n_cmp++; if (n >= 40 || bus.req_floor !== 4'd9 || bus.pending !== 16'h0300 || bus.dir_up !== 1'b0) begin n_bad++;
            $display("FAIL rst_setup: req=%0d pending=%h dir=%b expected 9/0300/0", bus.req_floor, bus.pending, bus.dir_up); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus.pending !== 16'd0 || bus.req_floor !== 4'd0 ||
                     {bus.go, bus.door_open_req, bus.served, bus.dir_up, bus.busy} !== 5'b00010) begin n_bad++;
            $display("FAIL rst_async: pending=%h req=%0d flags=%b expected 0000/0/00010", bus.pending, bus.req_floor,
                     {bus.go, bus.door_open_req, bus.served, bus.dir_up, bus.busy}); end
        @(negedge clk); reset = 1'b0;
        call(4'd3);
        wait_go(n);
        n_cmp++; if (n >= 40 || bus.req_floor !== 4'd3 || bus.pending !== 16'h0008) begin n_bad++;
            $display("FAIL rst_after: req=%0d pending=%h expected 3/0008", bus.req_floor, bus.pending); end
    endtask

`ifdef SCHED_CANCEL_EN
    task automatic test_cancel();
        int n; logic sv;
        do_reset(); bus.cur_floor = 4'd5;
        call(4'd3); call(4'd9);
        wait_go(n);
        n_cmp++; if (n >= 40 || bus.req_floor !== 4'd9) begin n_bad++; $display("FAIL cancel_go: req=%0d expected 9", bus.req_floor); end
        bus.cancel_valid = 1'b1; bus.cancel_floor = 4'd3; @(negedge clk);
        bus.cancel_floor = 4'd9; @(negedge clk);
        bus.cancel_valid = 1'b0;
        n_cmp++; if (bus.pending !== 16'h0200) begin n_bad++; $display("FAIL cancel_mask: got %h expected 0200", bus.pending); end
        arrive(4'd9, sv);
        n_cmp++; if (sv !== 1'b1 || bus.pending !== 16'd0) begin n_bad++;
            $display("FAIL cancel_serve: served=%b pending=%h expected 1/0000", sv, bus.pending); end
        count_door(n);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL cancel_idle: busy=%b expected 0", bus.busy); end
        bus.call_valid = 1'b1; bus.call_floor = 4'd4; bus.cancel_valid = 1'b1; bus.cancel_floor = 4'd4;
        @(negedge clk);
        bus.call_valid = 1'b0; bus.cancel_valid = 1'b0;
        n_cmp++; if (bus.pending !== 16'h0010) begin n_bad++; $display("FAIL cancel_callwins: got %h expected 0010", bus.pending); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_same_floor();
        test_scan_order();
        test_entry_cycle();
        test_reset_travel();
`ifdef SCHED_CANCEL_EN
        test_cancel();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
